// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames an audio sample stream for a streaming FFT core and
// turns the returned spectrum into per-bin magnitude estimates.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      allows a new frame to start (looked at in IDLE only)
//   sample_valid, sample_data   incoming signed audio samples
//   fft_start                   one-cycle frame-start pulse to the FFT core
//   fft_in_valid, fft_xn_re/im  time-domain samples to the FFT core (imag = 0)
//   fft_out_valid, fft_xk_re/im spectrum bins from the FFT core
//   bin_valid, bin_idx, bin_mag magnitude estimate |re| + |im| per bin
//   frame_done                  pulses together with the last bin
//   timeout_err                 sticky FFT-core timeout flag, cleared by fft_start
//   drop_cnt                    saturating count of samples seen outside LOAD
//   state                       IDLE=0, LOAD=1, WAIT=2, UNLOAD=3
module fft_frame_ctrl #(
   parameter int unsigned FFT_POINTS     = 1024,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          sample_valid,
   input  logic [DATA_WIDTH-1:0]         sample_data,
   output logic                          fft_start,
   output logic                          fft_in_valid,
   output logic [DATA_WIDTH-1:0]         fft_xn_re,
   output logic [DATA_WIDTH-1:0]         fft_xn_im,
   input  logic                          fft_out_valid,
   input  logic [DATA_WIDTH-1:0]         fft_xk_re,
   input  logic [DATA_WIDTH-1:0]         fft_xk_im,
   output logic                          bin_valid,
   output logic [$clog2(FFT_POINTS)-1:0] bin_idx,
   output logic [DATA_WIDTH-1:0]         bin_mag,
   output logic                          frame_done,
   output logic                          timeout_err,
   output logic [15:0]                   drop_cnt,
   output logic [1:0]                    state
);

   localparam int unsigned IdxW  = $clog2(FFT_POINTS);
   localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IdxW-1:0]  LastIdx  = IdxW'(FFT_POINTS - 1);
   localparam logic [WaitW-1:0] LastWait = WaitW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StWait   = 2'd2,
      StUnload = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  fft_start_q, fft_start_d;
   logic                  fft_in_valid_q, fft_in_valid_d;
   logic [DATA_WIDTH-1:0] fft_xn_re_q, fft_xn_re_d;
   logic                  bin_valid_q, bin_valid_d;
   logic [IdxW-1:0]       bin_idx_q, bin_idx_d;
   logic [DATA_WIDTH-1:0] bin_mag_q, bin_mag_d;
   logic                  frame_done_q, frame_done_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic [IdxW-1:0]       load_cnt_q, load_cnt_d;
   logic [IdxW-1:0]       bin_cnt_q, bin_cnt_d;
   logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;

   logic                  accept;
   logic                  beat;
   logic [DATA_WIDTH:0]   re_ext, im_ext, abs_re, abs_im, mag_sum;
   logic [DATA_WIDTH-1:0] mag_sat;

   // State register (all flops)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         fft_start_q    <= 1'b0;
         fft_in_valid_q <= 1'b0;
         fft_xn_re_q    <= '0;
         bin_valid_q    <= 1'b0;
         bin_idx_q      <= '0;
         bin_mag_q      <= '0;
         frame_done_q   <= 1'b0;
         timeout_err_q  <= 1'b0;
         drop_cnt_q     <= '0;
         load_cnt_q     <= '0;
         bin_cnt_q      <= '0;
         wait_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         fft_start_q    <= fft_start_d;
         fft_in_valid_q <= fft_in_valid_d;
         fft_xn_re_q    <= fft_xn_re_d;
         bin_valid_q    <= bin_valid_d;
         bin_idx_q      <= bin_idx_d;
         bin_mag_q      <= bin_mag_d;
         frame_done_q   <= frame_done_d;
         timeout_err_q  <= timeout_err_d;
         drop_cnt_q     <= drop_cnt_d;
         load_cnt_q     <= load_cnt_d;
         bin_cnt_q      <= bin_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
      end
   end

   // Next-state logic. The fft_start cycle itself is spent in IDLE, so LOAD
   // begins on the cycle after the pulse.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (fft_start_q) state_d = StLoad;
         StLoad:   if (sample_valid && load_cnt_q == LastIdx) state_d = StWait;
         StWait: begin
            if (fft_out_valid)               state_d = StUnload;
            else if (wait_cnt_q == LastWait) state_d = StIdle;
         end
         StUnload: if (fft_out_valid && bin_cnt_q == LastIdx) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Magnitude estimate: |re| + |im| in DATA_WIDTH+1 bits, then saturate.
   always_comb begin
      re_ext  = {fft_xk_re[DATA_WIDTH-1], fft_xk_re};
      im_ext  = {fft_xk_im[DATA_WIDTH-1], fft_xk_im};
      abs_re  = re_ext[DATA_WIDTH] ? ('0 - re_ext) : re_ext;
      abs_im  = im_ext[DATA_WIDTH] ? ('0 - im_ext) : im_ext;
      mag_sum = abs_re + abs_im;
      mag_sat = mag_sum[DATA_WIDTH] ? '1 : mag_sum[DATA_WIDTH-1:0];
   end

   // Output and counter logic
   always_comb begin
      accept = (state_q == StLoad) && sample_valid;
      beat   = fft_out_valid && ((state_q == StWait) || (state_q == StUnload));

      // enable is ignored while a start pulse is already in flight
      fft_start_d    = (state_q == StIdle) && !fft_start_q && enable;

      fft_in_valid_d = accept;
      fft_xn_re_d    = accept ? sample_data : fft_xn_re_q;
      load_cnt_d     = (state_q == StLoad) ? load_cnt_q + IdxW'(accept) : '0;

      bin_valid_d    = beat;
      bin_idx_d      = beat ? bin_cnt_q : bin_idx_q;
      bin_mag_d      = beat ? mag_sat : bin_mag_q;
      frame_done_d   = beat && (bin_cnt_q == LastIdx);
      bin_cnt_d      = ((state_q == StWait) || (state_q == StUnload)) ?
                       bin_cnt_q + IdxW'(beat) : '0;

      wait_cnt_d     = (state_q == StWait) ? wait_cnt_q + WaitW'(1) : '0;

      timeout_err_d  = timeout_err_q;
      if (state_q == StWait && !fft_out_valid && wait_cnt_q == LastWait) begin
         timeout_err_d = 1'b1;
      end
      if (fft_start_d) begin
         timeout_err_d = 1'b0;
      end

      drop_cnt_d = drop_cnt_q;
      if (sample_valid && state_q != StLoad && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   assign fft_start    = fft_start_q;
   assign fft_in_valid = fft_in_valid_q;
   assign fft_xn_re    = fft_xn_re_q;
   assign fft_xn_im    = '0;
   assign bin_valid    = bin_valid_q;
   assign bin_idx      = bin_idx_q;
   assign bin_mag      = bin_mag_q;
   assign frame_done   = frame_done_q;
   assign timeout_err  = timeout_err_q;
   assign drop_cnt     = drop_cnt_q;
   assign state        = state_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: 1024-point frames, 16-bit data, WAIT timeout of 100.
module tb_fft_frame_ctrl;

   localparam int N  = 1024;
   localparam int DW = 16;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          sample_valid;
   logic [DW-1:0] sample_data;
   logic          fft_start;
   logic          fft_in_valid;
   logic [DW-1:0] fft_xn_re;
   logic [DW-1:0] fft_xn_im;
   logic          fft_out_valid;
   logic [DW-1:0] fft_xk_re;
   logic [DW-1:0] fft_xk_im;
   logic          bin_valid;
   logic [9:0]    bin_idx;
   logic [DW-1:0] bin_mag;
   logic          frame_done;
   logic          timeout_err;
   logic [15:0]   drop_cnt;
   logic [1:0]    state;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   fft_frame_ctrl #(
      .FFT_POINTS    (N),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .fft_start    (fft_start),
      .fft_in_valid (fft_in_valid),
      .fft_xn_re    (fft_xn_re),
      .fft_xn_im    (fft_xn_im),
      .fft_out_valid(fft_out_valid),
      .fft_xk_re    (fft_xk_re),
      .fft_xk_im    (fft_xk_im),
      .bin_valid    (bin_valid),
      .bin_idx      (bin_idx),
      .bin_mag      (bin_mag),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err),
      .drop_cnt     (drop_cnt),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"},     32'(state), 0);
      check({tag, "_start"},     32'(fft_start), 0);
      check({tag, "_in_valid"},  32'(fft_in_valid), 0);
      check({tag, "_xn_re"},     32'(fft_xn_re), 0);
      check({tag, "_xn_im"},     32'(fft_xn_im), 0);
      check({tag, "_bin_valid"}, 32'(bin_valid), 0);
      check({tag, "_bin_idx"},   32'(bin_idx), 0);
      check({tag, "_bin_mag"},   32'(bin_mag), 0);
      check({tag, "_done"},      32'(frame_done), 0);
      check({tag, "_timeout"},   32'(timeout_err), 0);
      check({tag, "_drop"},      32'(drop_cnt), 0);
   endtask

   initial begin
      int exp_mag;

      // Reset with enable already high: no frame may start while held in reset.
      rst_n         = 1'b0;
      enable        = 1'b1;
      sample_valid  = 1'b0;
      sample_data   = '0;
      fft_out_valid = 1'b0;
      fft_xk_re     = '0;
      fft_xk_im     = '0;
      #1;
      check_all_zero("reset");
      tick();
      tick();
      check("reset_hold_start", 32'(fft_start), 0);
      rst_n = 1'b1;
      check("post_release_start", 32'(fft_start), 0);

      // First edge after release starts the frame; pulse lasts one cycle.
      tick();
      check("start_pulse", 32'(fft_start), 1);
      check("start_state", 32'(state), 0);
      enable = 1'b0;
      tick();
      check("start_pulse_end", 32'(fft_start), 0);
      check("load_entry_state", 32'(state), 1);

      // Ramp 0..1023 loaded back to back.
      for (int i = 0; i < N; i++) begin
         sample_valid = 1'b1;
         sample_data  = DW'(i);
         tick();
         check("load_valid", 32'(fft_in_valid), 1);
         check("load_data", 32'(fft_xn_re), 32'(i));
         check("load_state", 32'(state), (i == N - 1) ? 2 : 1);
      end
      sample_valid = 1'b0;
      tick();
      check("load_end_valid", 32'(fft_in_valid), 0);
      check("load_drop", 32'(drop_cnt), 0);

      // Five samples while waiting for the FFT core are dropped.
      sample_valid = 1'b1;
      repeat (5) tick();
      sample_valid = 1'b0;
      tick();
      check("wait_drop5", 32'(drop_cnt), 5);
      check("wait_state", 32'(state), 2);
      check("wait_no_bin", 32'(bin_valid), 0);

      // Unload 1024 bins: two corner vectors then re=i, im=-(i/2).
      for (int i = 0; i < N; i++) begin
         fft_out_valid = 1'b1;
         if (i == 0) begin
            fft_xk_re = 16'h8000;
            fft_xk_im = 16'h8000;
            exp_mag   = 65535;
         end else if (i == 1) begin
            fft_xk_re = 16'hFFFD;
            fft_xk_im = 16'h0004;
            exp_mag   = 7;
         end else begin
            fft_xk_re = DW'(i);
            fft_xk_im = DW'(0 - (i >> 1));
            exp_mag   = i + (i >> 1);
         end
         tick();
         check("bin_valid", 32'(bin_valid), 1);
         check("bin_idx", 32'(bin_idx), 32'(i));
         check("bin_mag", 32'(bin_mag), 32'(exp_mag));
         check("bin_done", 32'(frame_done), (i == N - 1) ? 1 : 0);
         check("unload_state", 32'(state), (i == N - 1) ? 0 : 3);
      end

      // fft_out_valid in IDLE is ignored.
      fft_xk_re = 16'h0010;
      fft_xk_im = 16'h0010;
      tick();
      check("idle_ignore_bin", 32'(bin_valid), 0);
      check("idle_done_clear", 32'(frame_done), 0);
      check("idle_state", 32'(state), 0);
      check("idle_no_restart", 32'(fft_start), 0);
      fft_out_valid = 1'b0;

      // Timeout frame; fft_out_valid held high through LOAD must be ignored.
      enable = 1'b1;
      tick();
      check("to_start", 32'(fft_start), 1);
      enable = 1'b0;
      tick();
      fft_out_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         sample_valid = 1'b1;
         sample_data  = DW'(i * 3);
         tick();
      end
      sample_valid  = 1'b0;
      fft_out_valid = 1'b0;
      check("load_ignore_bin", 32'(bin_valid), 0);
      check("to_wait_state", 32'(state), 2);
      repeat (TO - 1) tick();
      check("to_still_wait", 32'(state), 2);
      check("to_not_yet", 32'(timeout_err), 0);
      tick();
      check("to_idle", 32'(state), 0);
      check("to_err_set", 32'(timeout_err), 1);
      tick();
      check("to_err_sticky", 32'(timeout_err), 1);

      // Next fft_start clears the timeout flag.
      enable = 1'b1;
      tick();
      check("to_clear_start", 32'(fft_start), 1);
      check("to_err_cleared", 32'(timeout_err), 0);
      enable = 1'b0;
      tick();

      // Asynchronous reset at LOAD sample 500.
      for (int i = 0; i < 500; i++) begin
         sample_valid = 1'b1;
         sample_data  = DW'(i + 1);
         tick();
      end
      check("pre_reset_data", 32'(fft_xn_re), 500);
      sample_data = DW'(501);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      sample_valid = 1'b0;
      enable       = 1'b1;
      tick();
      check("fresh_start", 32'(fft_start), 1);
      enable = 1'b0;
      tick();
      check("fresh_load", 32'(state), 1);

      // Fresh frame must need a full 1024 samples again.
      sample_valid = 1'b1;
      sample_data  = 16'h0123;
      tick();
      check("fresh_first_data", 32'(fft_xn_re), 32'h0123);
      for (int i = 1; i < N - 1; i++) begin
         sample_data = DW'(i);
         tick();
      end
      check("fresh_1023_state", 32'(state), 1);
      tick();
      check("fresh_1024_state", 32'(state), 2);
      check("fresh_drop", 32'(drop_cnt), 0);

      // Drop counter saturation: 66000 samples outside LOAD.
      repeat (66000) tick();
      sample_valid = 1'b0;
      check("drop_sat", 32'(drop_cnt), 32'hFFFF);
      check("drop_sat_state", 32'(state), 0);
      check("drop_sat_timeout", 32'(timeout_err), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
